// File: rtl/adder_scheduler_pkg.sv
// Shared definitions for the adder scheduler.
//  - state_t      : scheduler FSM states
//  - DATA_W_DEF   : default operand/sum width
//  - clog2()      : index width helper, never returns less than 1
package adder_scheduler_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Width needed to index 'value' items; a single item still gets one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/adder_scheduler_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
//  i_req   : request vector
//  i_ptr   : index of the last granted requester
//  o_grant : one-hot grant (zero when no request)
//  o_idx   : index of the granted requester
//  o_any   : at least one request present
// The search starts at i_ptr+1 and wraps, so the last winner has lowest priority.
module adder_scheduler_rr_arbiter
  import adder_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  int w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand = int'(i_ptr) + off;
      if (w_cand >= NUM_REQ) w_cand = w_cand - NUM_REQ;
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = IDX_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/adder_scheduler.sv
// Shares one fixed-latency adder between NUM_REQ requesters.
// One transaction in flight: IDLE (arbitrate) -> ISSUE (pulse the adder)
// -> WAIT (count out the adder latency) -> RESP (hold result until taken).
// Ports:
//  clk, rst              : clock, asynchronous active-high reset
//  req_valid_i/ready_o   : per-requester handshake, ready is one-hot or zero
//  req_op1_i/req_op2_i   : packed operands, requester k at [k*DATA_W +: DATA_W]
//  add_op1_o/op2_o/valid_o, add_sum_i : adder interface
//  rsp_valid_o/ready_i, rsp_id_o, rsp_sum_o : response port
//  busy_o                : high whenever not idle
module adder_scheduler
  import adder_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADD_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0]   req_op1_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_op2_i,
  output logic [DATA_W-1:0]           add_op1_o,
  output logic [DATA_W-1:0]           add_op2_o,
  output logic                        add_valid_o,
  input  logic [DATA_W-1:0]           add_sum_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [clog2(NUM_REQ)-1:0]   rsp_id_o,
  output logic [DATA_W-1:0]           rsp_sum_o,
  output logic                        busy_o
);

  localparam int ID_W  = clog2(NUM_REQ);
  localparam int CNT_W = clog2(ADD_LAT + 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_id;
  logic [DATA_W-1:0]  r_op1;
  logic [DATA_W-1:0]  r_op2;
  logic [DATA_W-1:0]  r_sum;
  logic [CNT_W-1:0]   r_cnt;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic               w_accept;

  logic [DATA_W-1:0]  w_op1 [NUM_REQ];
  logic [DATA_W-1:0]  w_op2 [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_op1[gi] = req_op1_i[gi*DATA_W +: DATA_W];
      assign w_op2[gi] = req_op2_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  adder_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_arb (
    .i_req   (req_valid_i),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // The grant is derived from req_valid_i, so any grant in IDLE is a handshake.
  assign w_accept = (r_state == ST_IDLE) && w_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= ID_W'(NUM_REQ - 1);  // requester 0 wins first
      r_id    <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op1 <= w_op1[w_idx];
            r_op2 <= w_op2[w_idx];
            r_id  <= w_idx;
            r_ptr <= w_idx;
          end
        end
        ST_ISSUE: r_cnt <= CNT_W'(ADD_LAT - 1);
        ST_WAIT: begin
          // Counter reaching zero marks the edge ending cycle ISSUE+ADD_LAT.
          if (r_cnt == '0) r_sum <= add_sum_i;
          else             r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready_o  = '0;
    add_valid_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready_o = w_grant;
        if (w_any) w_state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        add_valid_o  = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Operands stay on the adder bus until the next grant overwrites them.
  assign add_op1_o = r_op1;
  assign add_op2_o = r_op2;
  assign rsp_id_o  = r_id;
  assign rsp_sum_o = r_sum;
  assign busy_o    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adder_scheduler.sv
module tb_adder_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ADD_LAT = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_op1 = '0;
  logic [NUM_REQ*DATA_W-1:0] req_op2 = '0;
  logic [DATA_W-1:0]         add_op1, add_op2, add_sum;
  logic                      add_valid;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b1;
  logic [1:0]                rsp_id;
  logic [DATA_W-1:0]         rsp_sum;
  logic                      busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  adder_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADD_LAT(ADD_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op1_i   (req_op1),
    .req_op2_i   (req_op2),
    .add_op1_o   (add_op1),
    .add_op2_o   (add_op2),
    .add_valid_o (add_valid),
    .add_sum_i   (add_sum),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_sum_o   (rsp_sum),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage adder with no reset; non-valid cycles inject garbage so that
  // sampling at the wrong time shows up as a wrong sum.
  logic [DATA_W-1:0] add_p1, add_p2;
  always @(posedge clk) begin
    add_p1 <= add_valid ? add_op1 + add_op2 : 8'hEE;
    add_p2 <= add_p1;
  end
  assign add_sum = add_p2;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  bit m_idle = 1'b1;
  int m_cnt = 0;          // cycles since accept
  int m_ptr = NUM_REQ - 1;
  int m_id = 0, m_sum = 0, m_a = 0, m_b = 0;
  int dut_acc = 0, dut_rsp = 0, dut_pulses = 0, aborted = 0;

  always @(negedge clk) begin
    int g, c;
    logic [NUM_REQ-1:0] exp_ready;
    if (rst) begin
      check("rst_busy", busy, 0);
      check("rst_ready", req_ready, 0);
      check("rst_add_valid", add_valid, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_sum", rsp_sum, 0);
      check("rst_add_ops", {add_op1, add_op2}, 0);
      if (!m_idle) aborted++;
      m_idle = 1'b1;
      m_cnt  = 0;
      m_ptr  = NUM_REQ - 1;
    end else begin
      g = -1;
      exp_ready = '0;
      if (m_idle) begin
        for (int off = 1; off <= NUM_REQ; off++) begin
          c = (m_ptr + off) % NUM_REQ;
          if (g < 0 && req_valid[c]) g = c;
        end
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      check("req_ready", req_ready, exp_ready);
      check("busy", busy, !m_idle);
      check("add_valid", add_valid, (!m_idle && m_cnt == 1));
      if (!m_idle && m_cnt == 1) begin
        check("add_op1", add_op1, m_a);
        check("add_op2", add_op2, m_b);
      end
      check("rsp_valid", rsp_valid, (!m_idle && m_cnt >= ADD_LAT + 2));
      if (!m_idle && m_cnt >= ADD_LAT + 2) begin
        check("rsp_id", rsp_id, m_id);
        check("rsp_sum", rsp_sum, m_sum);
      end
      if (req_valid & req_ready) dut_acc++;
      if (rsp_valid && rsp_ready) dut_rsp++;
      if (add_valid) dut_pulses++;
      // advance model
      if (m_idle) begin
        if (g >= 0) begin
          m_idle = 1'b0;
          m_cnt  = 1;
          m_id   = g;
          m_ptr  = g;
          m_a    = int'(req_op1[g*DATA_W +: DATA_W]);
          m_b    = int'(req_op2[g*DATA_W +: DATA_W]);
          m_sum  = (m_a + m_b) % 256;
        end
      end else if (m_cnt >= ADD_LAT + 2) begin
        if (rsp_ready) m_idle = 1'b1;
      end else begin
        m_cnt++;
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b);
    req_op1[k*DATA_W +: DATA_W] = a;
    req_op2[k*DATA_W +: DATA_W] = b;
    req_valid[k] = 1'b1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    check("idle_timeout", ok, 1);
  endtask

  task automatic do_req(input int k, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_sum);
    int acc, lat;
    bit got;
    @(posedge clk); #1;
    set_req(k, a, b);
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[k]) begin acc = cyc; break; end
    end
    check("accept_seen", (acc >= 0), 1);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    got = 0;
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; lat = cyc - acc; break; end
    end
    check("rsp_seen", got, 1);
    check("latency", lat, 4);
    check("lit_id", rsp_id, k);
    check("lit_sum", rsp_sum, exp_sum);
    @(negedge clk);
    check("resp_one_cycle", rsp_valid, 0);
    $display("txn req=%0d %02h+%02h -> id=%0d sum=%02h lat=%0d", k, a, b, k, exp_sum, lat);
  endtask

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int order [6];
    int gcyc  [6];
    int n, g;
    bit got;
    logic [NUM_REQ-1:0] granted;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_rsp_valid", rsp_valid, 0);

    // 1/2: basic and wrap-around sums
    do_req(0, 8'h12, 8'h34, 8'h46);
    do_req(2, 8'hFF, 8'h01, 8'h00);
    do_req(1, 8'h80, 8'h80, 8'h00);
    do_req(3, 8'h7F, 8'h01, 8'h80);

    // 3: all requesters valid, pointer now at 3 -> 0,1,2,3,0,1
    @(posedge clk); #1;
    for (int k = 0; k < NUM_REQ; k++) set_req(k, 8'(16 * k + 3), 8'(k + 32));
    n = 0;
    for (int i = 0; i < 80 && n < 6; i++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        order[n] = onehot_idx(req_ready);
        gcyc[n]  = cyc;
        n++;
      end
    end
    @(posedge clk); #1 req_valid = '0;
    check("rr_count", n, 6);
    for (int i = 0; i < n; i++) begin
      check("rr_order", order[i], i % NUM_REQ);
      if (i > 0) check("rr_interval", gcyc[i] - gcyc[i-1], 5);
      $display("txn rr grant=%0d cycle=%0d", order[i], gcyc[i]);
    end
    wait_idle();

    // 4: backpressure
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(1, 8'h05, 8'h06);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[1]) begin got = 1; break; end
    end
    check("bp_accept", got, 1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    set_req(2, 8'h09, 8'h0A);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; break; end
    end
    check("bp_rsp_seen", got, 1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_id", rsp_id, 1);
      check("bp_sum", rsp_sum, 8'h0B);
      check("bp_ready", req_ready, 0);
      check("bp_busy", busy, 1);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_valid", rsp_valid, 0);
    check("bp_release_grant", req_ready, 4'b0100);
    check("bp_release_busy", busy, 0);
    $display("txn backpressure id=1 sum=0b released, next grant=2");
    @(posedge clk); #1 req_valid[2] = 1'b0;
    wait_idle();
    wait_idle();

    // 5: reset during WAIT after granting requester 2
    @(posedge clk); #1;
    set_req(2, 8'h01, 8'h02);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[2]) begin got = 1; break; end
    end
    check("rst_case_accept", got, 1);
    @(posedge clk); #1 req_valid[2] = 1'b0;   // ISSUE cycle
    @(posedge clk); #1 rst = 1'b1;            // WAIT cycle
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_rsp_after_rst", rsp_valid, 0);
    end
    @(posedge clk); #1;
    set_req(1, 8'h21, 8'h22);
    set_req(3, 8'h31, 8'h32);
    g = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready != 0) begin g = onehot_idx(req_ready); break; end
    end
    check("rst_first_grant", g, 1);
    $display("txn after reset first grant=%0d", g);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready[3]) begin got = 1; break; end
    end
    check("rst_second_grant", got, 1);
    @(posedge clk); #1 req_valid[3] = 1'b0;
    wait_idle();

    // 6: random traffic
    granted = '0;
    for (int t = 0; t < 10000; t++) begin
      @(posedge clk); #1;
      rsp_ready = 1'($urandom_range(0, 1));
      for (int k = 0; k < NUM_REQ; k++) begin
        if (granted[k]) req_valid[k] = 1'b0;
        else if (!req_valid[k]) begin
          if ($urandom_range(0, 2) == 0)
            set_req(k, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end else if ($urandom_range(0, 19) == 0) req_valid[k] = 1'b0;
      end
      @(negedge clk);
      granted = req_valid & req_ready;
    end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();
    repeat (2) @(negedge clk);
    check("answered_once", dut_rsp, dut_acc - aborted);
    check("add_valid_pulses", dut_pulses, dut_acc);
    $display("txn random accepts=%0d responses=%0d aborted=%0d", dut_acc, dut_rsp, aborted);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
